// File: rtl/curve25519_pkg.sv
// curve25519_pkg: shared constants and types for the Edwards25519 datapath.
//   P          - field prime 2^255 - 19
//   P_MINUS_2  - Fermat inversion exponent 2^255 - 21
//   fe_t       - one field element
//   p2a_state_t- sequencer states of proj_to_affine
package curve25519_pkg;

    localparam int FE_W = 255;

    typedef logic [FE_W-1:0] fe_t;

    localparam fe_t P         = fe_t'((256'd1 << 255) - 256'd19);
    localparam fe_t P_MINUS_2 = fe_t'((256'd1 << 255) - 256'd21);

    // Bit 254 of the exponent is absorbed by starting the accumulator at Z,
    // so the square-and-multiply walk begins one bit lower.
    localparam logic [7:0] EXP_START_BIT = 8'd253;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SQR,
        ST_MUL,
        ST_FX,
        ST_FY,
        ST_DONE
    } p2a_state_t;

endpackage

// File: rtl/mult_modp.sv
// mult_modp: modular multiplier, prod = a*b mod (2^255 - 19).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (discards in-flight work)
//   en         - one-cycle start pulse; a/b must stay stable until dr
//   a, b       - operands, each < p
//   prod       - fully reduced product, valid from the dr cycle onward
//   dr         - one-cycle done pulse, three cycles after en
module mult_modp
    import curve25519_pkg::*;
#(
    parameter int N = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] prod,
    output logic         dr
);

    localparam int W1 = N + 5;

    logic [2*N-1:0] full_d, full_q;
    logic [W1-1:0]  fold_d, fold_q;
    logic [N-1:0]   prod_d, prod_q;
    logic           v1_d, v1_q, v2_d, v2_q, dr_d, dr_q;

    logic [W1-1:0]  hi_ext;
    logic [N:0]     top_ext;
    logic [N:0]     fold2;
    logic [N:0]     fold2_sub;
    logic [N:0]     p_ext;

    // Stage 1 captures the raw double-width product.
    always_comb begin
        full_d = full_q;
        if (en) begin
            full_d = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        end
    end

    // Stage 2 folds the high half back in using 2^255 == 19 (mod p);
    // the multiply by 19 is written as 16 + 2 + 1.
    always_comb begin
        hi_ext = {5'b0, full_q[2*N-1:N]};
        fold_d = fold_q;
        if (v1_q) begin
            fold_d = {5'b0, full_q[N-1:0]} + (hi_ext << 4) + (hi_ext << 1) + hi_ext;
        end
    end

    // Stage 3: the second fold leaves at most a few hundred above 2^255,
    // so a single conditional subtraction of p fully reduces it.
    always_comb begin
        top_ext   = {{(N-4){1'b0}}, fold_q[W1-1:N]};
        fold2     = {1'b0, fold_q[N-1:0]} + (top_ext << 4) + (top_ext << 1) + top_ext;
        p_ext     = (N+1)'(P);
        fold2_sub = fold2 - p_ext;
        prod_d    = prod_q;
        if (v2_q) begin
            prod_d = (fold2 >= p_ext) ? fold2_sub[N-1:0] : fold2[N-1:0];
        end
    end

    always_comb begin
        v1_d = en;
        v2_d = v1_q;
        dr_d = v2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            fold_q <= '0;
            prod_q <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            dr_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            fold_q <= fold_d;
            prod_q <= prod_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            dr_q   <= dr_d;
        end
    end

    assign prod = prod_q;
    assign dr   = dr_q;

endmodule

// File: rtl/proj_to_affine.sv
// proj_to_affine: converts a projective Edwards25519 point (X:Y:Z) into
// affine x = X/Z, y = Y/Z mod p, plus the compressed encoding {x[0], y}.
// 1/Z is Z^(p-2), computed left-to-right on one shared mult_modp.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake; in_ready only while idle
//   X, Y, Z              - projective coordinates (< p)
//   out_valid / out_ready- output handshake; results hold under backpressure
//   x, y                 - affine coordinates
//   enc                  - compressed point {x[0], y}
//   err                  - Z was zero (no affine image), qualified by out_valid
module proj_to_affine
    import curve25519_pkg::*;
#(
    parameter int N = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic [N-1:0] Z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic [255:0] enc,
    output logic         err
);

    p2a_state_t   state_d, state_q;
    logic [7:0]   bit_idx_d, bit_idx_q;
    logic         busy_d, busy_q;
    logic         mul_en_d, mul_en_q;
    logic [N-1:0] xr_d, xr_q;
    logic [N-1:0] yr_d, yr_q;
    logic [N-1:0] zr_d, zr_q;
    logic [N-1:0] acc_d, acc_q;
    logic [N-1:0] x_d, x_q;
    logic [N-1:0] y_d, y_q;
    logic         err_d, err_q;

    logic [N-1:0] mul_a, mul_b;
    logic [N-1:0] mul_prod;
    logic         mul_dr;
    logic         exp_bit;

    assign exp_bit = P_MINUS_2[bit_idx_q];

    // Operands come straight from the state and accumulator, both of which
    // only change on dr, so they stay stable for the whole operation.
    always_comb begin
        mul_a = acc_q;
        mul_b = acc_q;
        unique case (state_q)
            ST_MUL:  mul_b = zr_q;
            ST_FX:   mul_a = xr_q;
            ST_FY:   mul_a = yr_q;
            default: ;
        endcase
    end

    mult_modp #(.N(N)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mul_en_q),
        .a     (mul_a),
        .b     (mul_b),
        .prod  (mul_prod),
        .dr    (mul_dr)
    );

    // Sequencer. The first operation after accept is launched from the
    // not-busy cycle; every later one is launched from the dr cycle of its
    // predecessor, so back-to-back operations are L+1 cycles apart.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        mul_en_d  = 1'b0;
        xr_d      = xr_q;
        yr_d      = yr_q;
        zr_d      = zr_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    xr_d   = X;
                    yr_d   = Y;
                    zr_d   = Z;
                    busy_d = 1'b0;
                    if (Z == '0) begin
                        x_d     = '0;
                        y_d     = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        acc_d     = Z;
                        bit_idx_d = EXP_START_BIT;
                        err_d     = 1'b0;
                        state_d   = ST_SQR;
                    end
                end
            end

            ST_SQR, ST_MUL: begin
                if (!busy_q) begin
                    mul_en_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (mul_dr) begin
                    acc_d    = mul_prod;
                    mul_en_d = 1'b1;
                    if (state_q == ST_SQR && exp_bit) begin
                        state_d = ST_MUL;
                    end else if (bit_idx_q == 8'd0) begin
                        state_d = ST_FX;
                    end else begin
                        bit_idx_d = bit_idx_q - 8'd1;
                        state_d   = ST_SQR;
                    end
                end
            end

            ST_FX: begin
                if (!busy_q) begin
                    mul_en_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (mul_dr) begin
                    x_d      = mul_prod;
                    mul_en_d = 1'b1;
                    state_d  = ST_FY;
                end
            end

            ST_FY: begin
                if (!busy_q) begin
                    mul_en_d = 1'b1;
                    busy_d   = 1'b1;
                end else if (mul_dr) begin
                    y_d     = mul_prod;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            mul_en_q  <= 1'b0;
            xr_q      <= '0;
            yr_q      <= '0;
            zr_q      <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            mul_en_q  <= mul_en_d;
            xr_q      <= xr_d;
            yr_q      <= yr_d;
            zr_q      <= zr_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            y_q       <= y_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign x         = x_q;
    assign y         = y_q;
    assign err       = err_q;
    assign enc       = {x_q[0], y_q};

endmodule

// File: tb/tb_proj_to_affine.sv
// tb_proj_to_affine: table-driven, scoreboarded bench for proj_to_affine.
// Vectors are built from chosen affine points scaled by Z, so expected
// results never depend on an inversion model.
module tb_proj_to_affine;
    import curve25519_pkg::*;

    localparam int N = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] X_in = '0;
    logic [N-1:0] Y_in = '0;
    logic [N-1:0] Z_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] x_out;
    logic [N-1:0] y_out;
    logic [255:0] enc;
    logic         err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int meas_l = -1;

    typedef struct {
        fe_t  px, py, pz;
        fe_t  ex, ey;
        logic eerr;
    } vec_t;

    typedef struct {
        fe_t  ex, ey;
        logic eerr;
        int   acc_cyc;
        int   en_base;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    localparam fe_t BX = fe_t'(256'h216936D3CD6E53FEC0A4E231FDD6DC5C692CC7609525A7B2C9562D608F25D51A);
    localparam fe_t BY = fe_t'(256'h6666666666666666666666666666666666666666666666666666666666666658);

    proj_to_affine #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X_in),
        .Y         (Y_in),
        .Z         (Z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x_out),
        .y         (y_out),
        .enc       (enc),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic fe_t mulmod(input fe_t a, input fe_t b);
        logic [511:0] t;
        logic [511:0] m;
        t = {257'd0, a} * {257'd0, b};
        m = {257'd0, P};
        t = t % m;
        return t[254:0];
    endfunction

    function automatic fe_t rand_fe();
        logic [255:0] r;
        fe_t v;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        v = r[254:0];
        if (v >= P) v = v - P;
        return v;
    endfunction

    function automatic vec_t make_vec(input fe_t ax, input fe_t ay, input fe_t z);
        vec_t v;
        v.pz   = z;
        v.px   = mulmod(ax, z);
        v.py   = mulmod(ay, z);
        v.ex   = (z == '0) ? '0 : ax;
        v.ey   = (z == '0) ? '0 : ay;
        v.eerr = (z == '0);
        return v;
    endfunction

    // All sampling happens on the falling edge, one place, so cycle counts
    // and multiplier activity are tracked without races.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (dut.mul_en_q) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (dut.mul_dr) meas_l = cyc - en_cyc;
    endtask

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event, want event", name);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},  256'(in_ready),  256'(1));
        check({tag, " out_valid"}, 256'(out_valid), 256'(0));
        check({tag, " err"},       256'(err),       256'(0));
        check({tag, " x"},         256'(x_out),     256'(0));
        check({tag, " y"},         256'(y_out),     256'(0));
        check({tag, " enc"},       enc,             256'(0));
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   budget;
        X_in     = v.px;
        Y_in     = v.py;
        Z_in     = v.pz;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready && budget < 100) begin
            tick();
            budget++;
        end
        if (!in_ready) begin
            fail_now("accept");
            in_valid = 1'b0;
            return;
        end
        e.ex      = v.ex;
        e.ey      = v.ey;
        e.eerr    = v.eerr;
        e.acc_cyc = cyc;
        e.en_base = en_cnt;
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        check("in_ready drop", 256'(in_ready), 256'(0));
    endtask

    task automatic checkOutput(input int hold);
        exp_t         e;
        int           budget;
        int           lat;
        logic [255:0] want_enc;
        fe_t          hx, hy;
        logic [255:0] henc;
        logic         herr;
        logic         stable;
        budget = 0;
        while (!out_valid && budget < 4000) begin
            tick();
            budget++;
        end
        if (!out_valid) begin
            fail_now("out_valid");
            return;
        end
        if (sb.size() == 0) begin
            fail_now("scoreboard entry");
            return;
        end
        e        = sb.pop_front();
        lat      = cyc - e.acc_cyc;
        want_enc = {e.ex[0], e.ey};
        check("x",   256'(x_out), 256'(e.ex));
        check("y",   256'(y_out), 256'(e.ey));
        check("enc", enc,         want_enc);
        check("err", 256'(err),   256'(e.eerr));
        if (e.eerr) begin
            check("latency z0",  256'(lat),                256'(1));
            check("en pulses z0", 256'(en_cnt - e.en_base), 256'(0));
        end else begin
            check("latency",   256'(lat),                256'(2 + 508 * (meas_l + 1)));
            check("en pulses", 256'(en_cnt - e.en_base), 256'(508));
        end
        if (hold > 0) begin
            hx     = x_out;
            hy     = y_out;
            henc   = enc;
            herr   = err;
            stable = 1'b1;
            for (int k = 0; k < hold; k++) begin
                tick();
                if (x_out !== hx || y_out !== hy || enc !== henc || err !== herr ||
                    out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            end
            check("hold stable", 256'(stable), 256'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready return", 256'(in_ready),  256'(1));
        check("out_valid clear", 256'(out_valid), 256'(0));
    endtask

    initial begin
        int   budget;
        logic seen;

        vecs[0] = make_vec(fe_t'(0), fe_t'(1), fe_t'(1));
        vecs[1] = make_vec(fe_t'(1), fe_t'(2), fe_t'(2));
        vecs[2] = make_vec(BX, BY, fe_t'(7));
        vecs[3] = make_vec(fe_t'(5), fe_t'(9), fe_t'(0));
        vecs[3].px = fe_t'(5);
        vecs[3].py = fe_t'(9);
        vecs[4] = make_vec(P - fe_t'(1), P - fe_t'(2), P - fe_t'(1));
        for (int i = 5; i < 7; i++) begin
            fe_t z;
            z = rand_fe();
            if (z == '0) z = fe_t'(1);
            vecs[i] = make_vec(rand_fe(), rand_fe(), z);
        end

        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(0);
        end
        check("mult latency sane", 256'(meas_l > 0 && meas_l < 64), 256'(1));

        $display("[TB] backpressure sequence");
        applyStimulus(vecs[1]);
        checkOutput(20);
        applyStimulus(vecs[2]);
        checkOutput(0);

        $display("[TB] reset during exponentiation");
        applyStimulus(vecs[5]);
        budget = 0;
        while (dut.bit_idx_q != 8'd100 && budget < 3000) begin
            tick();
            budget++;
        end
        if (dut.bit_idx_q != 8'd100) fail_now("reach bit 100");
        rst_n = 1'b0;
        #1;
        check_reset_values("midop reset");
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("no output after reset", 256'(seen), 256'(0));
        applyStimulus(vecs[1]);
        checkOutput(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
